vga_sync_decoder: RTL

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Purpose: recovers pixel x/y, line/frame strobes and a lock indication from raw VGA sync and DE.
// Latency: every output is registered; an input change reaches the outputs 2 clocks later.
// Backpressure: none; one pixel per clock is always accepted, outputs are free-running strobes.
module vga_sync_decoder #(
   parameter int LOCK_FRAMES = 2,
   parameter int H_MIN       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        h_sync,
   input  logic        v_sync,
   input  logic        display_on,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic        pix_valid,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] h_total,
   output logic [15:0] v_total,
   output logic        locked,
   output logic        sync_err
);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   // Two-deep input history; edges are detected between the older and newer sample.
   logic hs1, vs1, de1;
   logic hs2, vs2, de2;
   logic hs_fall, vs_fall, de_rise, de_fall;

   logic [15:0] h_cnt, v_cnt;
   logic [15:0] h_meas, v_meas;
   logic        frame_armed;

   state_t      state, state_next;
   logic [15:0] match_cnt, match_next;
   logic        frame_bad, bad_next, bad_acc;
   logic [15:0] h_total_next, v_total_next;
   logic        err_next;
   logic        lock_next;

   assign hs_fall = hs2 & ~hs1;
   assign vs_fall = vs2 & ~vs1;
   assign de_rise = ~de2 & de1;
   assign de_fall = de2 & ~de1;

   // Measurement of the line / frame that ends on this sync edge; a same-cycle hsync counts toward the frame.
   assign h_meas = h_cnt + 16'd1;
   assign v_meas = v_cnt + {15'd0, hs_fall};

   // Input sampling pipeline, idling at syncs high and DE low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {hs1, vs1, de1} <= 3'b110;
         {hs2, vs2, de2} <= 3'b110;
      end else begin
         {hs1, vs1, de1} <= {h_sync, v_sync, display_on};
         {hs2, vs2, de2} <= {hs1, vs1, de1};
      end
   end

   // Clock-per-line counter (saturating, so a dead hsync is detectable) and line-per-frame counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         if (hs_fall)
            h_cnt <= '0;
         else if (h_cnt != 16'hFFFF)
            h_cnt <= h_cnt + 16'd1;

         if (vs_fall)
            v_cnt <= '0;
         else if (hs_fall)
            v_cnt <= v_cnt + 16'd1;
      end
   end

   // Lock FSM: next state, match tracking and measured totals.
   always_comb begin
      state_next   = state;
      match_next   = match_cnt;
      bad_next     = frame_bad;
      bad_acc      = frame_bad;
      h_total_next = h_total;
      v_total_next = v_total;
      err_next     = 1'b0;
      unique case (state)
         SEARCH: begin
            // The frame in progress when we start watching is partial, so it never counts.
            if (vs_fall) begin
               state_next = MEASURE;
               match_next = '0;
               bad_next   = 1'b1;
            end
         end
         MEASURE: begin
            if (hs_fall) begin
               if ((h_meas != h_total) || (h_meas < 16'(H_MIN)))
                  bad_acc = 1'b1;
               h_total_next = h_meas;
            end
            bad_next = bad_acc;
            if (vs_fall) begin
               if (!bad_acc && (v_meas == v_total))
                  match_next = match_cnt + 16'd1;
               else
                  match_next = '0;
               v_total_next = v_meas;
               bad_next     = 1'b0;
               if (match_next == 16'(LOCK_FRAMES))
                  state_next = LOCKED;
            end
         end
         LOCKED: begin
            // Totals are frozen here so they still show the last good timing after a loss.
            if ((hs_fall && (h_meas != h_total)) ||
                (vs_fall && (v_meas != v_total)) ||
                (h_cnt == 16'hFFFF)) begin
               err_next   = 1'b1;
               state_next = SEARCH;
            end
         end
         default: state_next = SEARCH;
      endcase
      lock_next = (state_next == LOCKED);
   end

   // Lock FSM registers; locked mirrors the LOCKED state exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SEARCH;
         match_cnt <= '0;
         frame_bad <= 1'b0;
         h_total   <= '0;
         v_total   <= '0;
         locked    <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         state     <= state_next;
         match_cnt <= match_next;
         frame_bad <= bad_next;
         h_total   <= h_total_next;
         v_total   <= v_total_next;
         locked    <= lock_next;
         sync_err  <= err_next;
      end
   end

   // Pixel address and strobes, qualified by the lock decision made in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x           <= '0;
         y           <= '0;
         pix_valid   <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_armed <= 1'b0;
      end else begin
         pix_valid   <= de1 & lock_next;
         line_start  <= de_rise & lock_next;
         frame_start <= de_rise & lock_next & frame_armed;

         if (vs_fall)
            frame_armed <= 1'b1;
         else if (de_rise && lock_next)
            frame_armed <= 1'b0;

         if (de_rise)
            x <= '0;
         else if (de1)
            x <= x + 16'd1;
         else if (de_fall)
            x <= '0;

         if (vs_fall)
            y <= '0;
         else if (de_fall)
            y <= y + 16'd1;
      end
   end

endmodule
